// File: rtl/execute_memory_pipe.sv
// EX/MEM pipeline boundary: valid/ready handshake with a 2-slot skid buffer,
// flush-to-bubble and optional suppression of register-0 writes.
module execute_memory_pipe #(
  parameter int DATA_W             = 32,
  parameter int REG_ADDR_W         = 5,
  parameter int WIDTH_W            = 2,
  parameter int ZERO_DEST_SUPPRESS = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Flush,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic                  RegWrite_In,
  input  logic                  MemToReg_In,
  input  logic                  R_Enable_In,
  input  logic                  W_Enable_In,
  input  logic [WIDTH_W-1:0]    R_Width_In,
  input  logic [WIDTH_W-1:0]    W_Width_In,
  input  logic [DATA_W-1:0]     ALUResult_In,
  input  logic [DATA_W-1:0]     Reg_Data2_In,
  input  logic [REG_ADDR_W-1:0] rDestSelected_In,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic                  RegWrite_Out,
  output logic                  MemToReg_Out,
  output logic                  R_Enable_Out,
  output logic                  W_Enable_Out,
  output logic [WIDTH_W-1:0]    R_Width_Out,
  output logic [WIDTH_W-1:0]    W_Width_Out,
  output logic [DATA_W-1:0]     ALUResult_Out,
  output logic [DATA_W-1:0]     Reg_Data2_Out,
  output logic [REG_ADDR_W-1:0] rDestSelected_Out,
  output logic [1:0]            Occupancy
);

  typedef struct packed {
    logic                  rw;
    logic                  m2r;
    logic                  ren;
    logic                  wen;
    logic [WIDTH_W-1:0]    rwid;
    logic [WIDTH_W-1:0]    wwid;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     d2;
    logic [REG_ADDR_W-1:0] dest;
  } ent_t;

  // State encoding equals the number of held entries, so it drives Occupancy directly.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0] r_state;
  logic       r_in_ready;
  ent_t       r_main, r_skid;

  ent_t       w_in;
  logic       w_accept, w_pop;
  logic [1:0] w_nxt_state;
  logic       w_load_main, w_load_skid, w_skid_to_main;

  always_comb begin
    w_in      = '0;
    w_in.rw   = RegWrite_In & ((ZERO_DEST_SUPPRESS == 0) || (rDestSelected_In != '0));
    w_in.m2r  = MemToReg_In;
    w_in.ren  = R_Enable_In;
    w_in.wen  = W_Enable_In;
    w_in.rwid = R_Width_In;
    w_in.wwid = W_Width_In;
    w_in.alu  = ALUResult_In;
    w_in.d2   = Reg_Data2_In;
    w_in.dest = rDestSelected_In;
  end

  assign w_accept = In_Valid & r_in_ready;
  assign w_pop    = Out_Valid & Out_Ready;

  always_comb begin
    w_nxt_state    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (Flush) begin
      w_nxt_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) begin
          w_load_main = 1'b1;
          w_nxt_state = ST_ONE;
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_nxt_state = ST_TWO;
          end else if (w_pop) begin
            w_nxt_state = ST_EMPTY;
          end
        end
        ST_TWO: if (w_pop) begin
          w_skid_to_main = 1'b1;
          w_nxt_state    = ST_ONE;
        end
        default: w_nxt_state = ST_EMPTY;
      endcase
    end
  end

  // In_Ready comes from a flop so Out_Ready never reaches it combinationally.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_in_ready <= (w_nxt_state != ST_TWO);
      if (w_load_main)         r_main <= w_in;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid)         r_skid <= w_in;
    end
  end

  assign In_Ready          = r_in_ready;
  assign Out_Valid         = (r_state != ST_EMPTY);
  assign Occupancy         = r_state;
  assign RegWrite_Out      = Out_Valid & r_main.rw;
  assign MemToReg_Out      = Out_Valid & r_main.m2r;
  assign R_Enable_Out      = Out_Valid & r_main.ren;
  assign W_Enable_Out      = Out_Valid & r_main.wen;
  assign R_Width_Out       = r_main.rwid;
  assign W_Width_Out       = r_main.wwid;
  assign ALUResult_Out     = r_main.alu;
  assign Reg_Data2_Out     = r_main.d2;
  assign rDestSelected_Out = r_main.dest;

endmodule
